// File: rtl/pwm_ctrl_pkg.sv
// Shared types, default widths and helpers for the PWM fade controller
// and its prescaler.
package pwm_ctrl_pkg;

    localparam int COUNTER_WIDTH_DEF  = 10;
    localparam int PRESCALE_WIDTH_DEF = 8;
    localparam int STEP_WIDTH_DEF     = 6;
    localparam int HOLD_WIDTH_DEF     = 8;

    // Wide enough for any of the configurable fields above.
    localparam int EFF_WIDTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } fade_state_e;

    // A programmed zero means "one": a zero step or zero dwell would stall the ramp.
    function automatic logic [EFF_WIDTH-1:0] eff_value(input logic [EFF_WIDTH-1:0] v);
        return (v == '0) ? EFF_WIDTH'(1) : v;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running reload down-counter producing the PWM counter-advance tick.
// A new reload value is picked up only when the count reaches zero.
module pwm_prescaler
    import pwm_ctrl_pkg::*;
#(
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      pwm_set_o
);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      at_zero;

    always_comb begin
        at_zero = (cnt_q == '0);
        cnt_d   = at_zero ? prescale_i : cnt_q - PRESCALE_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count sits at zero throughout reset, so the tick is masked there.
    assign pwm_set_o = at_zero && !rst;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for one PWM channel: ramps the compare value to a target
// in fixed steps, dwelling a programmable number of PWM periods per step.
//   state | meaning
//   IDLE  | ready for a fade command, compare value static
//   RAMP  | stepping toward target on every hold-th period event
module pwm_fade_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int COUNTER_WIDTH  = COUNTER_WIDTH_DEF,
    parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
    parameter int STEP_WIDTH     = STEP_WIDTH_DEF,
    parameter int HOLD_WIDTH     = HOLD_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [COUNTER_WIDTH-1:0]  cfg_target_i,
    input  logic [STEP_WIDTH-1:0]     cfg_step_i,
    input  logic [HOLD_WIDTH-1:0]     cfg_hold_i,
    input  logic                      abort_i,
    input  logic                      period_start_i,
    output logic [COUNTER_WIDTH-1:0]  cmp_value_o,
    output logic                      pwm_set_o,
    output logic                      busy_o,
    output logic                      done_o
);

    fade_state_e               state_q, state_d;
    logic                      ps_q, ps_d;
    logic                      per_evt_q, per_evt_d;
    logic [COUNTER_WIDTH-1:0]  target_q, target_d;
    logic [STEP_WIDTH-1:0]     step_q, step_d;
    logic [HOLD_WIDTH-1:0]     hold_rld_q, hold_rld_d;
    logic [HOLD_WIDTH-1:0]     hold_q, hold_d;
    logic [COUNTER_WIDTH-1:0]  cmp_q, cmp_d;
    logic                      done_q, done_d;

    logic [COUNTER_WIDTH:0]    cmp_ext, tgt_ext, step_ext, up_sum, down_gap;
    logic [COUNTER_WIDTH-1:0]  step_next;
    logic [HOLD_WIDTH-1:0]     hold_eff;

    pwm_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .prescale_i (prescale_i),
        .pwm_set_o  (pwm_set_o)
    );

    // Only the rising edge of period_start counts; it may stay high for many cycles.
    always_comb begin
        ps_d      = period_start_i;
        per_evt_d = period_start_i && !ps_q;
    end

    // One extra bit so the upward sum cannot wrap; the downward path never goes below target.
    always_comb begin
        cmp_ext  = {1'b0, cmp_q};
        tgt_ext  = {1'b0, target_q};
        step_ext = (COUNTER_WIDTH+1)'(step_q);
        up_sum   = cmp_ext + step_ext;
        down_gap = cmp_ext - tgt_ext;
        if (cmp_q < target_q) begin
            step_next = (up_sum >= tgt_ext) ? target_q : up_sum[COUNTER_WIDTH-1:0];
        end else begin
            step_next = (down_gap <= step_ext) ? target_q
                                               : cmp_q - COUNTER_WIDTH'(step_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        step_d      = step_q;
        hold_rld_d  = hold_rld_q;
        hold_d      = hold_q;
        cmp_d       = cmp_q;
        done_d      = 1'b0;
        hold_eff    = HOLD_WIDTH'(eff_value(EFF_WIDTH'(cfg_hold_i)));
        cfg_ready_o = (state_q == IDLE) && !rst;
        busy_o      = (state_q == RAMP);

        case (state_q)
            IDLE: begin
                if (cfg_valid_i && cfg_ready_o) begin
                    target_d   = cfg_target_i;
                    step_d     = STEP_WIDTH'(eff_value(EFF_WIDTH'(cfg_step_i)));
                    hold_rld_d = hold_eff;
                    if (cfg_target_i == cmp_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                        hold_d  = hold_eff;
                    end
                end
            end
            RAMP: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (per_evt_q) begin
                    if (hold_q <= HOLD_WIDTH'(1)) begin
                        cmp_d  = step_next;
                        hold_d = hold_rld_q;
                        if (step_next == target_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q - HOLD_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ps_q       <= 1'b0;
            per_evt_q  <= 1'b0;
            target_q   <= '0;
            step_q     <= '0;
            hold_rld_q <= '0;
            hold_q     <= '0;
            cmp_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ps_q       <= ps_d;
            per_evt_q  <= per_evt_d;
            target_q   <= target_d;
            step_q     <= step_d;
            hold_rld_q <= hold_rld_d;
            hold_q     <= hold_d;
            cmp_q      <= cmp_d;
            done_q     <= done_d;
        end
    end

    assign cmp_value_o = cmp_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: a table of chained fade commands plus
// hand-written sequences for ramps, abort races, sustained starts and reset.
module tb_pwm_fade_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] prescale_i;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [9:0] cfg_target_i;
    logic [5:0] cfg_step_i;
    logic [7:0] cfg_hold_i;
    logic       abort_i;
    logic       period_start_i;
    logic [9:0] cmp_value_o;
    logic       pwm_set_o;
    logic       busy_o;
    logic       done_o;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    pwm_fade_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .prescale_i     (prescale_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_target_i   (cfg_target_i),
        .cfg_step_i     (cfg_step_i),
        .cfg_hold_i     (cfg_hold_i),
        .abort_i        (abort_i),
        .period_start_i (period_start_i),
        .cmp_value_o    (cmp_value_o),
        .pwm_set_o      (pwm_set_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (busy_o) busy_cnt++;
    end

    typedef struct {
        int target;
        int step;
        int hold;
        int exp_periods;
        int exp_cmp;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int t, input int s, input int h, input logic abrt);
        cfg_target_i = 10'(t);
        cfg_step_i   = 6'(s);
        cfg_hold_i   = 8'(h);
        abort_i      = abrt;
        cfg_valid_i  = 1'b1;
        tick();
        cfg_valid_i  = 1'b0;
        abort_i      = 1'b0;
    endtask

    task automatic pulse_period(input int n);
        period_start_i = 1'b1;
        repeat (n) tick();
        period_start_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        vec_t vecs[6];
        int   exp_up[8];
        int   d0, b0, periods;

        vecs[0] = '{target: 5,    step: 3,  hold: 1, exp_periods: 0,  exp_cmp: 5};
        vecs[1] = '{target: 1020, step: 63, hold: 1, exp_periods: 17, exp_cmp: 1020};
        vecs[2] = '{target: 1023, step: 63, hold: 1, exp_periods: 1,  exp_cmp: 1023};
        vecs[3] = '{target: 0,    step: 63, hold: 3, exp_periods: 51, exp_cmp: 0};
        vecs[4] = '{target: 7,    step: 2,  hold: 0, exp_periods: 4,  exp_cmp: 7};
        vecs[5] = '{target: 4,    step: 5,  hold: 2, exp_periods: 2,  exp_cmp: 4};
        exp_up  = '{0, 30, 30, 60, 60, 90, 90, 100};

        rst = 1'b1;
        prescale_i = 8'd3;
        cfg_valid_i = 1'b0;
        cfg_target_i = '0;
        cfg_step_i = '0;
        cfg_hold_i = '0;
        abort_i = 1'b0;
        period_start_i = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst cmp", int'(cmp_value_o), 0);
        check("rst pwm_set", int'(pwm_set_o), 0);
        check("rst ready", int'(cfg_ready_o), 0);
        check("rst busy", int'(busy_o), 0);
        check("rst done", int'(done_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("prescale3 pwm_set c%0d", i), int'(pwm_set_o), (i % 4 == 0) ? 1 : 0);
            if (i == 0) check("ready after rst", int'(cfg_ready_o), 1);
        end

        // Upward ramp 0 -> 100, step 30, hold 2
        d0 = done_cnt;
        send_cmd(100, 30, 2, 1'b0);
        @(negedge clk);
        check("up busy", int'(busy_o), 1);
        for (int k = 0; k < 8; k++) begin
            pulse_period(1);
            check($sformatf("up cmp p%0d", k + 1), int'(cmp_value_o), exp_up[k]);
        end
        check("up done pulses", done_cnt - d0, 1);
        check("up busy after", int'(busy_o), 0);
        check("up ready after", int'(cfg_ready_o), 1);

        // Downward ramp 100 -> 5 with zero step and hold meaning one
        d0 = done_cnt;
        send_cmd(5, 0, 0, 1'b0);
        for (int i = 1; i <= 95; i++) begin
            pulse_period(1);
            check($sformatf("down cmp p%0d", i), int'(cmp_value_o), 100 - i);
        end
        check("down done pulses", done_cnt - d0, 1);
        pulse_period(1);
        check("down hold at target", int'(cmp_value_o), 5);

        // Chained command table
        for (int v = 0; v < 6; v++) begin
            d0 = done_cnt;
            b0 = busy_cnt;
            send_cmd(vecs[v].target, vecs[v].step, vecs[v].hold, 1'b0);
            tick();
            tick();
            periods = 0;
            while (done_cnt == d0 && periods < 100) begin
                pulse_period(1);
                periods++;
            end
            check($sformatf("vec%0d periods", v), periods, vecs[v].exp_periods);
            check($sformatf("vec%0d cmp", v), int'(cmp_value_o), vecs[v].exp_cmp);
            check($sformatf("vec%0d done pulses", v), done_cnt - d0, 1);
            check($sformatf("vec%0d busy after", v), int'(busy_o), 0);
            if (vecs[v].exp_periods == 0)
                check($sformatf("vec%0d busy cycles", v), busy_cnt - b0, 0);
        end

        // Abort coincident with a period event
        d0 = done_cnt;
        send_cmd(100, 10, 1, 1'b0);
        pulse_period(1);
        check("abort pre-step cmp", int'(cmp_value_o), 14);
        period_start_i = 1'b1;
        tick();
        period_start_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        @(negedge clk);
        check("abort cmp frozen", int'(cmp_value_o), 14);
        check("abort busy", int'(busy_o), 0);
        check("abort ready", int'(cfg_ready_o), 1);
        pulse_period(1);
        check("abort cmp idle", int'(cmp_value_o), 14);
        check("abort no done", done_cnt - d0, 0);

        // Abort in IDLE does not block a coincident command
        d0 = done_cnt;
        send_cmd(20, 10, 1, 1'b1);
        @(negedge clk);
        check("idle abort accepted", int'(busy_o), 1);
        pulse_period(1);
        check("idle abort cmp", int'(cmp_value_o), 20);
        check("idle abort done", done_cnt - d0, 1);

        // Sustained period_start counts once
        d0 = done_cnt;
        send_cmd(30, 5, 2, 1'b0);
        pulse_period(5);
        check("sustained one event", int'(cmp_value_o), 20);
        pulse_period(5);
        check("sustained second", int'(cmp_value_o), 25);
        pulse_period(1);
        pulse_period(1);
        check("sustained final", int'(cmp_value_o), 30);
        check("sustained done", done_cnt - d0, 1);

        // Reset mid-ramp
        send_cmd(100, 1, 1, 1'b0);
        pulse_period(1);
        check("midrst pre cmp", int'(cmp_value_o), 31);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("midrst cmp", int'(cmp_value_o), 0);
        check("midrst busy", int'(busy_o), 0);
        check("midrst done", int'(done_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("midrst ready", int'(cfg_ready_o), 1);
        check("midrst no done", done_cnt - d0, 0);

        // Prescale zero gives a constant tick
        prescale_i = 8'd0;
        repeat (6) tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("prescale0 pwm_set c%0d", i), int'(pwm_set_o), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Sequencing controller for one `pwm` channel. It generates the counter-advance tick (`pwm_set`) from a programmable prescaler and ramps the compare value from its present level to a requested target. The ramp moves in fixed steps and dwells a programmable number of PWM periods on each step. It sits between the register/config interface and the `pwm` instance, and accepts one fade command at a time over a valid/ready handshake.

## Interface
- `COUNTER_WIDTH`, 10: width of the `pwm` counter and compare value.
- `PRESCALE_WIDTH`, 8: width of the prescaler reload value.
- `STEP_WIDTH`, 6: width of the per-step duty increment.
- `HOLD_WIDTH`, 8: width of the dwell count, in PWM periods per step.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous reset, active-high.
- `prescale_i`  in  PRESCALE_WIDTH  `pwm_set_o` fires every `prescale_i+1` cycles.
- `cfg_valid_i`  in  1  fade command valid.
- `cfg_ready_o`  out  1  controller can accept a command.
- `cfg_target_i`  in  COUNTER_WIDTH  target compare value.
- `cfg_step_i`  in  STEP_WIDTH  increment per step; 0 is treated as 1.
- `cfg_hold_i`  in  HOLD_WIDTH  periods per step; 0 is treated as 1.
- `abort_i`  in  1  stop the ramp and freeze the current compare value.
- `period_start_i`  in  1  `period_start_o` from `pwm`.
- `cmp_value_o`  out  COUNTER_WIDTH  drives `pwm` `cmp_value_i`.
- `pwm_set_o`  out  1  drives `pwm` `pwm_set_i`.
- `busy_o`  out  1  ramp in progress.
- `done_o`  out  1  one-cycle pulse when the target is reached.

## Operation
- **Reset.** While `rst` is high, all outputs are 0 and the state is IDLE. The prescaler count and hold count clear to 0.
- **Prescaler.** Free-running down-counter loaded with `prescale_i`.
  - `pwm_set_o` is high for one cycle when the count is 0, then the counter reloads.
  - `prescale_i=0` gives `pwm_set_o` constantly high after reset.
  - A change to `prescale_i` takes effect at the next reload.
- **Period detection.** `period_start_i` can stay high for several cycles when ticks are sparse, so only its rising edge counts as a period event (`per_evt`). The edge register resets to 0.
- **IDLE state.**
  - `cfg_ready_o=1`, `busy_o=0`.
  - On `cfg_valid_i && cfg_ready_o`, latch the target, the effective step and the effective hold.
  - If target == `cmp_value_o`: pulse `done_o` next cycle and stay in IDLE.
  - Otherwise go to RAMP with hold count = effective hold.
- **RAMP state.**
  - `cfg_ready_o=0`, `busy_o=1`.
  - On each `per_evt`, decrement the hold count.
  - When the hold count goes 1→0, apply one step and reload the hold count.
- **Step rule.** Arithmetic is done in COUNTER_WIDTH+1 bits, with no wrap in either direction.
  - If cmp < target: cmp = min(cmp+step, target).
  - If cmp > target: cmp = max(cmp−step, target), computed without underflow.
  - When the new cmp equals the target: go to IDLE and pulse `done_o` one cycle later.
- **Abort.**
  - In RAMP, `abort_i` returns to IDLE with `cmp_value_o` held and no `done_o`.
  - `abort_i` has priority over a coincident `per_evt`.
  - `abort_i` in IDLE has no effect, and a command presented in the same cycle is still accepted.
- **Reset mid-ramp.** `cmp_value_o` goes to 0 and any pending `done_o` is dropped.

## Timing
- `cfg_ready_o` is combinational from the state.
- Command accepted at edge N → `busy_o` high from cycle N+1.
- `per_evt` asserts in the cycle after `period_start_i` rises.
- The step is applied at the edge ending the `per_evt` cycle. `cmp_value_o` therefore changes 2 cycles after `period_start_i` rises, ahead of the next period latch in `pwm`.
- `done_o` is high in the cycle after the final step is written, and `busy_o` falls in that same cycle.
- Ramp length = ceil(|target−start|/step) × hold periods.

## Structure
- Package `pwm_ctrl_pkg`:
  - state enum `fade_state_e` {IDLE, RAMP}
  - default width constants
  - the effective-value helper (maps 0 to 1)
- Sub-module `pwm_prescaler`: the reload counter and `pwm_set_o` generation, reusable for other channels.
- The top level holds the handshake, edge detect, hold counter and step arithmetic.

## Test plan
- **Reset values.** Hold `rst` high 3 cycles → all outputs 0. After release: `cfg_ready_o=1`; with `prescale_i=3`, `pwm_set_o` pulses every 4 cycles.
- **Upward ramp.** From cmp=0, command target=100, step=30, hold=2 → cmp sequence 30, 60, 90, 100, each after 2 period events. `done_o` is a single pulse and `busy_o` is low afterwards.
- **Downward ramp.** From cmp=100, command target=5, step=0 (effective 1), hold=0 (effective 1) → cmp decreases by 1 per period to 5 with no underflow, then `done_o`.
- **Saturation.** From cmp=1020 with COUNTER_WIDTH=10, command target=1023, step=63 → a single step to 1023 with no wrap.
- **Abort race.** Assert `abort_i` in the same cycle as `per_evt` mid-ramp → no step is applied, state returns to IDLE, `done_o` stays 0, and `cfg_ready_o=1` the next cycle.
- **Null command and sustained start.** Command target == current cmp → `done_o` pulse 1 cycle later, `busy_o` never high. Separately, hold `period_start_i` high for 5 cycles → counts as exactly one period event.
